// File: rtl/eth_tx_ctrl.sv
// eth_tx_ctrl: RMII frame serialiser with CRC feed, payload fetch and inter-packet gap
module eth_tx_ctrl #(
  parameter int pIPG_Clks = 48
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [47:0] Dest_Addr,
  input  logic [47:0] Src_Addr,
  input  logic [15:0] Len_Type,
  input  logic [15:0] Payload_Len,
  output logic        Payload_Rd,
  input  logic [7:0]  Payload_Data,
  input  logic [31:0] Crc_Computed,
  output logic        Crc_Init,
  output logic        Crc_En,
  output logic [7:0]  Byte_Out,
  output logic        Byte_Vld,
  output logic [1:0]  Txd,
  output logic        Tx_En,
  output logic        Busy,
  output logic        Done
);
  typedef enum logic [2:0] {IDLE, PRE, SFD, HDR, PAY, FCS, IPG} state_t;
  state_t       state, nxt;
  logic [15:0]  cnt, last, n_len;
  logic [1:0]   phase;
  logic [7:0]   shreg, nbyte;
  logic [143:0] hdr;
  logic [23:0]  fcs;
  logic         wrap, cov;
  assign Txd = shreg[1:0];
  // nxt/nbyte describe the byte loaded at the coming phase-3 edge
  always_comb begin
    last = state == PRE ? 16'd6 : state == HDR ? 16'd17 : state == PAY ? n_len - 16'd1 :
           state == FCS ? 16'd3 : 16'd0;
    wrap = cnt == last;
    nxt = !wrap ? state : state == PRE ? SFD : state == SFD ? HDR :
          state == HDR ? (n_len == 16'd0 ? FCS : PAY) : state == PAY ? FCS : IPG;
    nbyte = nxt == PRE ? 8'h55 : nxt == SFD ? 8'hD5 : nxt == HDR ? hdr[143:136] :
            nxt == PAY ? Payload_Data :
            nxt == FCS ? (state == FCS ? fcs[23:16] : Crc_Computed[31:24]) : 8'h00;
    cov = nxt == HDR || nxt == PAY;
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state <= IDLE;
      cnt <= '0;
      n_len <= '0;
      phase <= '0;
      shreg <= '0;
      hdr <= '0;
      fcs <= '0;
      Payload_Rd <= 1'b0;
      Crc_Init <= 1'b0;
      Crc_En <= 1'b0;
      Byte_Out <= '0;
      Byte_Vld <= 1'b0;
      Tx_En <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Crc_Init <= 1'b0;
      Byte_Vld <= 1'b0;
      Payload_Rd <= 1'b0;
      Done <= 1'b0;
      if (state == IDLE) begin
        if (Start) begin
          // cnt of all-ones rolls to byte 0 of the preamble on the first load
          state <= PRE;
          cnt <= '1;
          phase <= 2'd3;
          Busy <= 1'b1;
          Crc_Init <= 1'b1;
          n_len <= Payload_Len;
          hdr <= {Dest_Addr, Src_Addr, Len_Type, 8'h00, Payload_Len, 8'h00};
        end
      end else if (state == IPG) begin
        cnt <= cnt + 16'd1;
        if (cnt == 16'(pIPG_Clks - 1)) begin
          state <= IDLE;
          Busy <= 1'b0;
          Done <= 1'b1;
        end
      end else if (phase != 2'd3) begin
        phase <= phase + 2'd1;
        shreg <= shreg >> 2;
        Payload_Rd <= phase == 2'd1 && nxt == PAY;
      end else begin
        phase <= 2'd0;
        state <= nxt;
        cnt <= wrap ? 16'd0 : cnt + 16'd1;
        shreg <= nbyte;
        Tx_En <= nxt != IPG;
        Crc_En <= cov;
        Byte_Vld <= cov;
        if (cov) Byte_Out <= nbyte;
        if (nxt == HDR) hdr <= hdr << 8;
        if (nxt == FCS) fcs <= state == FCS ? fcs << 8 : Crc_Computed[23:0];
      end
    end
endmodule

// File: tb/tb_eth_tx_ctrl.sv
// tb_eth_tx_ctrl: scoreboard bench rebuilding bytes from Txd and checking CRC feed and timing
module tb_eth_tx_ctrl;
  logic        Clk = 0, Rst = 0, Start = 0;
  logic [47:0] Dest_Addr = '0, Src_Addr = '0;
  logic [15:0] Len_Type = '0, Payload_Len = '0;
  logic        Payload_Rd, Crc_Init, Crc_En, Byte_Vld, Tx_En, Busy, Done;
  logic [7:0]  Payload_Data = '0, Byte_Out;
  logic [31:0] Crc_Computed = '0;
  logic [1:0]  Txd;

  eth_tx_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Dest_Addr(Dest_Addr), .Src_Addr(Src_Addr),
    .Len_Type(Len_Type), .Payload_Len(Payload_Len), .Payload_Rd(Payload_Rd),
    .Payload_Data(Payload_Data), .Crc_Computed(Crc_Computed), .Crc_Init(Crc_Init),
    .Crc_En(Crc_En), .Byte_Out(Byte_Out), .Byte_Vld(Byte_Vld), .Txd(Txd), .Tx_En(Tx_En),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int errors = 0, checks = 0;
  int ncyc = 0, s_cyc = 0, done_at = 0;
  int txen_clks = 0, rd_cnt = 0, vld_cnt = 0, done_cnt = 0, ph = 0, pidx = 0;
  logic [7:0] acc = '0;
  logic [7:0] exp_q[$], crc_q[$], pay[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor: deserialise Txd, model the payload FIFO, pop scoreboards
  always @(negedge Clk) begin
    ncyc++;
    if (Rst) begin
      ph = 0;
      acc = '0;
    end else begin
      if (Tx_En) begin
        txen_clks++;
        acc = {Txd, acc[7:2]};
        ph++;
        if (ph == 4) begin
          if (exp_q.size() == 0) chk("stream_extra", 1, 0);
          else chk("stream_byte", acc, exp_q.pop_front());
          ph = 0;
        end
      end else chk("txd_idle", Txd, 0);
      if (Payload_Rd) begin
        rd_cnt++;
        Payload_Data = pidx < pay.size() ? pay[pidx] : 8'hxx;
        pidx++;
      end
      if (Byte_Vld) begin
        vld_cnt++;
        chk("crc_en_with_vld", Crc_En, 1);
        if (crc_q.size() == 0) chk("byte_vld_extra", 1, 0);
        else chk("byte_out", Byte_Out, crc_q.pop_front());
      end
      if (Done) begin
        done_cnt++;
        done_at = ncyc;
      end
    end
  end

  task automatic send(input logic [47:0] d, input logic [47:0] s, input logic [15:0] lt,
                      input int n, input logic [31:0] crc);
    logic [143:0] h;
    @(negedge Clk);
    #1;
    h = {d, s, lt, 8'h00, 16'(n), 8'h00};
    pay.delete();
    pidx = 0;
    for (int i = 0; i < n; i++) pay.push_back(8'(i + 1));
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 18; i++) begin
      exp_q.push_back(h[143 - 8 * i -: 8]);
      crc_q.push_back(h[143 - 8 * i -: 8]);
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pay[i]);
      crc_q.push_back(pay[i]);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(crc[31 - 8 * i -: 8]);
    Dest_Addr = d;
    Src_Addr = s;
    Len_Type = lt;
    Payload_Len = 16'(n);
    Crc_Computed = crc;
    txen_clks = 0;
    rd_cnt = 0;
    vld_cnt = 0;
    done_cnt = 0;
    s_cyc = ncyc;
    Start = 1;
    @(negedge Clk);
    #1;
    Start = 0;
    chk("busy_at_k", Busy, 1);
    chk("crc_init_at_k", Crc_Init, 1);
    chk("txen_low_at_k", Tx_En, 0);
    @(negedge Clk);
    #1;
    chk("txen_at_k1", Tx_En, 1);
    chk("txd_first", Txd, 2'b01);
    chk("crc_init_once", Crc_Init, 0);
  endtask

  task automatic finish_frame(input int n);
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      @(negedge Clk);
      #1;
    end
    chk("done_seen", done_cnt, 1);
    chk("busy_drop_at_done", Busy, 0);
    chk("done_time", done_at - s_cyc, 2 + (30 + n) * 4 + 48);
    chk("txen_clocks", txen_clks, (30 + n) * 4);
    chk("payload_rd_count", rd_cnt, n);
    chk("byte_vld_count", vld_cnt, 22 + n - 4);
    chk("stream_left", exp_q.size(), 0);
    chk("crc_bytes_left", crc_q.size(), 0);
    @(negedge Clk);
    #1;
    chk("done_one_cycle", Done, 0);
  endtask

  initial begin
    #2 Rst = 1;
    #1;
    chk("rst_txen", Tx_En, 0);
    chk("rst_txd", Txd, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_outs", {Payload_Rd, Crc_Init, Crc_En, Byte_Vld, Byte_Out}, 0);
    repeat (2) @(negedge Clk);
    #1 Rst = 0;
    @(negedge Clk);
    #1;
    chk("idle_busy", Busy, 0);

    send(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 4, 32'hDEADBEEF);
    finish_frame(4);

    send(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, 0, 32'h12345678);
    finish_frame(0);

    send(48'h001122334455, 48'h66778899AABB, 16'h86DD, 6, 32'hA5C3_0F96);
    for (int i = 0; i < 1000 && rd_cnt < 2; i++) begin
      @(negedge Clk);
      #1;
    end
    chk("reached_payload", rd_cnt >= 2, 1);
    Dest_Addr = 48'hBADBADBADBAD;
    Payload_Len = 16'd9;
    Start = 1;
    @(negedge Clk);
    #1 Start = 0;
    finish_frame(6);
    repeat (300) @(negedge Clk);
    #1;
    chk("busy_start_ignored_done", done_cnt, 1);
    chk("busy_start_ignored_txen", txen_clks, (30 + 6) * 4);

    send(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 8, 32'h0BADF00D);
    for (int i = 0; i < 1000 && rd_cnt < 3; i++) begin
      @(negedge Clk);
      #1;
    end
    @(negedge Clk);
    #2 Rst = 1;
    #1;
    chk("midrst_txen", Tx_En, 0);
    chk("midrst_txd", Txd, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_outs", {Payload_Rd, Crc_En, Byte_Vld}, 0);
    @(negedge Clk);
    #1 Rst = 0;
    exp_q.delete();
    crc_q.delete();
    send(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 2, 32'hCAFEF00D);
    finish_frame(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
